store_buffer: RTL and testbench

- In-order store queue between the MEM-stage store issue point and the memwr DPI write stage.
- Accepts committed stores as {address, raw data, size} and aligns each to an 8-byte doubleword (byte mask plus shifted data).
- Buffers up to DEPTH stores and drains one per cycle into memwr's MemWr/addr/wmask/data.
- Flags loads that overlap a pending store so the pipeline can stall them.

---
 rtl/npc_mem_pkg.sv | 39 +++
 rtl/mem_align.sv | 23 ++
 rtl/store_buffer.sv | 120 ++++++++++++
 tb/tb_store_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// Shared memory-access encodings and alignment helpers for the store path and
// the load-overlap checker.
package npc_mem_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  wmask;
    logic [63:0] data;
  } sb_entry_t;

  // Byte-lane mask within the doubleword; lanes past byte 7 are dropped.
  function automatic logic [7:0] size_to_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      MEM_B:   base = 8'h01;
      MEM_H:   base = 8'h03;
      MEM_W:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      MEM_H:   mis = off[0];
      MEM_W:   mis = |off[1:0];
      MEM_D:   mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational doubleword alignment: lane mask, lane-shifted data, aligned
// address and misalignment flag for one access.
module mem_align
  import npc_mem_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [1:0]  size,
  input  logic [63:0] data,
  output logic [63:0] addr_al,
  output logic [7:0]  mask,
  output logic [63:0] data_al,
  output logic        misalign
);

  logic [2:0] off;

  assign off      = addr[2:0];
  assign addr_al  = {addr[63:3], 3'b000};
  assign mask     = size_to_mask(size, off);
  assign data_al  = data << {off, 3'b000};
  assign misalign = is_misaligned(size, off);

endmodule

// File: rtl/store_buffer.sv
// In-order store queue: aligns committed stores, drains one per cycle to the
// memory write port and flags loads that overlap any buffered store.
module store_buffer
  import npc_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [63:0] st_addr,
  input  logic [63:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_misalign,
  input  logic        wr_ready,
  output logic        MemWr,
  output logic [63:0] addr,
  output logic [7:0]  wmask,
  output logic [63:0] data,
  input  logic        ld_valid,
  input  logic [63:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_conflict,
  output logic        empty,
  output logic        full
);

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [63:0] st_addr_al, st_data_al, ld_addr_al, ld_data_al;
  logic [7:0]  st_mask, ld_mask;
  logic        st_mis, ld_mis;
  logic        push, pop, ld_hit;
  logic        unused_ld;

  mem_align u_st_align (
    .addr(st_addr), .size(st_size), .data(st_data),
    .addr_al(st_addr_al), .mask(st_mask), .data_al(st_data_al), .misalign(st_mis)
  );

  mem_align u_ld_align (
    .addr(ld_addr), .size(ld_size), .data(64'd0),
    .addr_al(ld_addr_al), .mask(ld_mask), .data_al(ld_data_al), .misalign(ld_mis)
  );

  assign unused_ld = ^{ld_data_al, ld_mis, ld_addr_al[2:0]};

  // Occupancy comes from the counter, so full and empty stay distinct when pointers meet.
  assign empty       = (count_q == '0);
  assign full        = (count_q == (PTR_W+1)'(DEPTH));
  assign st_ready    = ~full;
  assign st_misalign = st_valid & st_mis;
  assign push        = st_valid & st_ready & ~st_mis;
  assign MemWr       = ~empty & wr_ready;
  assign pop         = MemWr;

  assign addr  = empty ? 64'd0 : entry_q[head_q].addr;
  assign wmask = empty ? 8'd0  : entry_q[head_q].wmask;
  assign data  = empty ? 64'd0 : entry_q[head_q].data;

  always_comb begin
    entry_d = '{addr: st_addr_al, wmask: st_mask, data: st_data_al};
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The popping head still counts; a store pushed this cycle is not yet visible.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].addr[63:3] == ld_addr_al[63:3]) &&
          |(entry_q[i].wmask & ld_mask))
        ld_hit = 1'b1;
    end
    ld_conflict = ld_valid & ld_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) entry_q[tail_q] <= entry_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios followed by random traffic, all
// checked against a queue-based reference of the store buffer's behaviour.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_ready, st_misalign;
  logic [63:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        wr_ready, MemWr;
  logic [63:0] addr, data;
  logic [7:0]  wmask;
  logic        ld_valid, ld_conflict;
  logic [63:0] ld_addr;
  logic [1:0]  ld_size;
  logic        empty, full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  m;
    logic [63:0] d;
  } ent_t;

  ent_t q[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_misalign(st_misalign),
    .wr_ready(wr_ready), .MemWr(MemWr), .addr(addr), .wmask(wmask), .data(data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_conflict(ld_conflict),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Bytes touched: [off, off+n) clipped to the doubleword.
  function automatic logic [7:0] m_mask(logic [1:0] sz, logic [63:0] a);
    int n   = 1 << sz;
    int off = int'(a[2:0]);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + n) r[b] = 1'b1;
    return r;
  endfunction

  // Byte b of the lane-shifted data is source byte b-off.
  function automatic logic [63:0] m_data(logic [63:0] a, logic [63:0] d);
    int off = int'(a[2:0]);
    logic [63:0] r = '0;
    for (int b = 0; b < 8; b++) if (b >= off) r[8*b +: 8] = d[8*(b-off) +: 8];
    return r;
  endfunction

  function automatic logic m_mis(logic [1:0] sz, logic [63:0] a);
    return (a % (64'd1 << sz)) != 64'd0;
  endfunction

  function automatic logic m_conf();
    logic r = 1'b0;
    if (!ld_valid) return 1'b0;
    foreach (q[i])
      if (q[i].a[63:3] == ld_addr[63:3] && (q[i].m & m_mask(ld_size, ld_addr)) != 8'd0) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    int n = q.size();
    chk("empty", 64'(empty), 64'(n == 0));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("st_ready", 64'(st_ready), 64'(n != DEPTH));
    chk("MemWr", 64'(MemWr), 64'(n > 0 && wr_ready));
    chk("addr", addr, n > 0 ? q[0].a : 64'd0);
    chk("wmask", 64'(wmask), n > 0 ? 64'(q[0].m) : 64'd0);
    chk("data", data, n > 0 ? q[0].d : 64'd0);
    chk("st_misalign", 64'(st_misalign), 64'(st_valid && m_mis(st_size, st_addr)));
    chk("ld_conflict", 64'(ld_conflict), 64'(m_conf()));
  endtask

  task automatic tick();
    logic push, pop;
    ent_t e;
    #1;
    chk_outs();
    push = st_valid && !m_mis(st_size, st_addr) && q.size() < DEPTH;
    pop  = q.size() > 0 && wr_ready;
    e.a  = {st_addr[63:3], 3'b000};
    e.m  = m_mask(st_size, st_addr);
    e.d  = m_data(st_addr, st_data);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
    st_valid = 1'b1; st_addr = a; st_size = sz; st_data = d;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
    wr_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
    #1 rst = 1'b1;
    #2;
    chk_outs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte store lands in lane 5 and drains the next cycle
    wr_ready = 1'b1;
    store(64'h8000_0005, 2'd0, 64'hAB);
    #1;
    chk("t1_MemWr", 64'(MemWr), 64'd1);
    chk("t1_addr", addr, 64'h8000_0000);
    chk("t1_wmask", 64'(wmask), 64'h20);
    chk("t1_data", data, 64'h0000_AB00_0000_0000);
    tick();
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill with the port stalled, one extra push refused, then drain in order
    wr_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) store(64'h100 + 64'(8*i), 2'd3, {$urandom, $urandom});
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_st_ready", 64'(st_ready), 64'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("t2_order", addr, 64'h100 + 64'(8*i));
      tick();
    end
    chk("t2_empty", 64'(empty), 64'd1);

    // Misaligned word is refused; misaligned-looking half at 0x1006 is legal
    wr_ready = 1'b0;
    st_valid = 1'b1; st_addr = 64'h1002; st_size = 2'd2; st_data = 64'h1122_3344;
    #1 chk("t3_misalign", 64'(st_misalign), 64'd1);
    tick();
    st_valid = 1'b0;
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_MemWr", 64'(MemWr), 64'd0);
    store(64'h1006, 2'd1, 64'hBEEF);
    chk("t3_wmask", 64'(wmask), 64'hC0);
    wr_ready = 1'b1;
    tick();

    // Load overlap against a pending word store at 0x2004
    wr_ready = 1'b0;
    store(64'h2004, 2'd2, 64'hDEAD_BEEF);
    ld_valid = 1'b1; ld_size = 2'd0;
    ld_addr = 64'h2006; #1 chk("t4_hit", 64'(ld_conflict), 64'd1);
    ld_addr = 64'h2003; #1 chk("t4_below", 64'(ld_conflict), 64'd0);
    ld_addr = 64'h200C; #1 chk("t4_next_dw", 64'(ld_conflict), 64'd0);
    tick();
    ld_valid = 1'b0;
    wr_ready = 1'b1;
    tick();

    // Push and pop together at occupancy two
    wr_ready = 1'b0;
    store(64'h3000, 2'd3, 64'hA0A0_A0A0_A0A0_A0A0);
    store(64'h3008, 2'd3, 64'hB1B1_B1B1_B1B1_B1B1);
    wr_ready = 1'b1;
    #1 chk("t5_head_data", data, 64'hA0A0_A0A0_A0A0_A0A0);
    store(64'h3010, 2'd3, 64'hC2C2_C2C2_C2C2_C2C2);
    chk("t5_next_data", data, 64'hB1B1_B1B1_B1B1_B1B1);
    for (int i = 0; i < 2; i++) tick();
    chk("t5_empty", 64'(empty), 64'd1);

    // Asynchronous reset mid-cycle discards three pending stores
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(64'h4000 + 64'(8*i), 2'd3, {$urandom, $urandom});
    wr_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("t6_MemWr", 64'(MemWr), 64'd0);
    chk("t6_wmask", 64'(wmask), 64'd0);
    chk("t6_addr", addr, 64'd0);
    chk("t6_data", data, 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Random traffic in a small address window so overlaps are frequent
    for (int i = 0; i < 400; i++) begin
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 64'h5000 + 64'($urandom_range(0, 31));
      st_size  = 2'($urandom_range(0, 3));
      st_data  = {$urandom, $urandom};
      wr_ready = ($urandom_range(0, 2) != 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 64'h5000 + 64'($urandom_range(0, 31));
      ld_size  = 2'($urandom_range(0, 3));
      tick();
    end
    st_valid = 1'b0; ld_valid = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    chk("final_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
